// File: rtl/select_zero_32.sv
// Two-stage select: returns the bit position of the k-th zero (LSB-first, 0-based) of a 32-bit vector.
// One request per cycle, results appear exactly two cycles after pass, in order.
module select_zero_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        pass,
  input  logic [31:0] x,
  input  logic [4:0]  k,
  output logic        valid_r,
  output logic        found_r,
  output logic [4:0]  pos_r
);

  localparam int unsigned W   = 32;
  localparam int unsigned NIB = 8;
  localparam int unsigned CW  = 3;
  localparam int unsigned RW  = 5;
  localparam int unsigned PW  = 6;

  // Number of zero bits in a nibble, 0..4.
  function automatic logic [CW-1:0] nib_zeros(input logic [3:0] nib);
    logic [3:0] z;
    z = ~nib;
    return CW'(z[0]) + CW'(z[1]) + CW'(z[2]) + CW'(z[3]);
  endfunction

  // Index of the r-th zero inside a nibble; only meaningful when that zero exists.
  function automatic logic [1:0] kth_zero(input logic [3:0] nib, input logic [1:0] r);
    logic [2:0] seen;
    logic [1:0] b;
    seen = '0;
    b    = '0;
    for (int j = 0; j < 4; j++) begin
      if (!nib[j]) begin
        if (seen == {1'b0, r}) b = 2'(j);
        seen = seen + 3'd1;
      end
    end
    return b;
  endfunction

  logic [NIB-1:0][CW-1:0] cnt_d;
  logic [NIB-1:0][CW-1:0] cnt_q;
  logic [W-1:0]           x_q;
  logic [RW-1:0]          k_q;
  logic                   v1_q;

  logic [NIB:0][PW-1:0]   pre;
  logic [PW-1:0]          k6;
  logic [PW-1:0]          base;
  logic [2:0]             sel_n;
  logic [1:0]             resid;
  logic [1:0]             bit_b;
  logic                   found_d;
  logic [RW-1:0]          pos_d;

  logic                   valid_q;
  logic                   found_q;
  logic [RW-1:0]          pos_q;

  // S0: per-nibble zero counts
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NIB; i++) begin
      cnt_d[i] = nib_zeros(x[4*i +: 4]);
    end
  end

  // R1: data captured only on an accepted request; the valid flag is the only reset state
  always_ff @(posedge clk) begin
    if (rst) v1_q <= 1'b0;
    else     v1_q <= pass;
  end

  always_ff @(posedge clk) begin
    if (pass) begin
      cnt_q <= cnt_d;
      x_q   <= x;
      k_q   <= k;
    end
  end

  // S1: exclusive prefix sums, nibble selection and in-nibble select
  always_comb begin
    pre    = '0;
    sel_n  = '0;
    k6     = {1'b0, k_q};
    for (int i = 0; i < NIB; i++) begin
      pre[i+1] = pre[i] + PW'(cnt_q[i]);
    end
    // Empty nibbles have P[i]==P[i+1] and never match, so the hit is unique.
    for (int i = 0; i < NIB; i++) begin
      if ((pre[i] <= k6) && (k6 < pre[i+1])) sel_n = 3'(i);
    end
    base    = pre[sel_n];
    resid   = 2'(k6 - base);
    bit_b   = kth_zero(x_q[{sel_n, 2'b00} +: 4], resid);
    found_d = (k6 < pre[NIB]);
    pos_d   = found_d ? {sel_n, bit_b} : '0;
  end

  // R2: result registers; found/pos hold while no result is flowing
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      found_q <= 1'b0;
      pos_q   <= '0;
    end else begin
      valid_q <= v1_q;
      if (v1_q) begin
        found_q <= found_d;
        pos_q   <= pos_d;
      end
    end
  end

  assign valid_r = valid_q;
  assign found_r = found_q;
  assign pos_r   = pos_q;

endmodule
